// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU (AND/OR/ADD/SUB/XOR/SLT/SHL, optional iterative MUL).
// Latency: 1 cycle for single-cycle ops; WIDTH+1 cycles from accept to out_valid for MUL.
// Backpressure: one op in flight; in_ready is low until the result is taken (out_valid & out_ready).
//
// Optional feature macro: ALU_MUL_EN
//   defined   -> op 111 is an unsigned shift-add multiplier (BUSY state + multiplier registers)
//   undefined -> op 111 completes in one cycle with y=0, flag_err=1, flag_z=1
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, op)
//   out_valid/out_ready result handshake (y, flag_z/n/c/v/err)
//   op: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT (signed), 110 SHL, 111 MUL
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef ALU_MUL_EN
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
`endif

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, err_q, err_d;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   ma_q, ma_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
`endif

  // Single-cycle datapath results, evaluated on the live operands.
  logic [WIDTH-1:0] b_op;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r_y;
  logic             r_c, r_v, r_err;

  always_comb begin
    // SUB is a + ~b + 1 so carry-out reads as NOT borrow.
    b_op  = (op == OP_SUB) ? ~b : b;
    cin   = (op == OP_SUB);
    sum   = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    r_y   = '0;
    r_c   = 1'b0;
    r_v   = 1'b0;
    r_err = 1'b0;
    case (op)
      OP_AND: r_y = a & b;
      OP_OR:  r_y = a | b;
      OP_ADD, OP_SUB: begin
        r_y = sum[WIDTH-1:0];
        r_c = sum[WIDTH];
        r_v = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR: r_y = a ^ b;
      OP_SLT: r_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SHL: r_y = a << b[SHW-1:0];
      OP_MUL: begin
        // Only reached here when the multiplier is compiled out.
        r_y   = '0;
`ifdef ALU_MUL_EN
        r_err = 1'b0;
`else
        r_err = 1'b1;
`endif
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
    err_d   = err_q;
`ifdef ALU_MUL_EN
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
`ifdef ALU_MUL_EN
          if (op == OP_MUL) begin
            ma_d    = a;
            mb_d    = b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_BUSY;
          end else begin
`else
          begin
`endif
            y_d     = r_y;
            z_d     = (r_y == '0);
            n_d     = r_y[WIDTH-1];
            c_d     = r_c;
            v_d     = r_v;
            err_d   = r_err;
            state_d = S_DONE;
          end
        end
      end
`ifdef ALU_MUL_EN
      S_BUSY: begin
        // One partial product per cycle; the last step also publishes the result.
        acc_d = acc_q + (mb_q[cnt_q] ? ({{WIDTH{1'b0}}, ma_q} << cnt_q) : '0);
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          y_d     = acc_d[WIDTH-1:0];
          z_d     = (acc_d[WIDTH-1:0] == '0);
          n_d     = acc_d[WIDTH-1];
          c_d     = |acc_d[2*WIDTH-1:WIDTH];
          v_d     = 1'b0;
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_MUL_EN
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      err_q   <= err_d;
`ifdef ALU_MUL_EN
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign flag_err  = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (WIDTH=32) against an arithmetic model.
// Latency: checks 1-cycle ops and, with ALU_MUL_EN, the WIDTH+1-cycle multiply.
// Backpressure: holds out_ready low with stray in_valid pulses and checks outputs stay frozen.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] y;
  logic        flag_z, flag_n, flag_c, flag_v, flag_err;
  logic [4:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;

  assign flags = {flag_z, flag_n, flag_c, flag_v, flag_err};

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (%0d tests, %0d failed)", n_tests, n_fail);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  // Flags are packed {z, n, c, v, err}.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic [2:0] mop,
                       output logic [31:0] ey, output logic [4:0] ef, output int elat);
    longint unsigned u;
    longint          s;
    logic            c, v, e;
    c = 1'b0; v = 1'b0; e = 1'b0; elat = 1; ey = '0;
    case (mop)
      3'd0: ey = ma & mb;
      3'd1: ey = ma | mb;
      3'd2: begin
        u  = longint'(ma) + longint'(mb);
        ey = u[31:0];
        c  = u[32];
        s  = longint'($signed(ma)) + longint'($signed(mb));
        v  = (s != longint'($signed(ey)));
      end
      3'd3: begin
        ey = ma - mb;
        c  = (ma >= mb);
        s  = longint'($signed(ma)) - longint'($signed(mb));
        v  = (s != longint'($signed(ey)));
      end
      3'd4: ey = ma ^ mb;
      3'd5: ey = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
      3'd6: ey = ma << mb[4:0];
      default: begin
`ifdef ALU_MUL_EN
        u    = longint'(ma) * longint'(mb);
        ey   = u[31:0];
        c    = (u[63:32] != 0);
        elat = 33;
`else
        ey   = '0;
        e    = 1'b1;
`endif
      end
    endcase
    ef = {(ey == 32'd0), ey[31], c, v, e};
  endtask

  // Issue one op, check latency and result, hold the result for bp cycles
  // with stray input traffic, then release it and check the return to idle.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic [2:0] top, input int bp);
    logic [31:0] ey;
    logic [4:0]  ef;
    int          elat;
    int          lat;
    model(ta, tb_, top, ey, ef, elat);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    a = ta; b = tb_; op = top; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(elat));
    chk({tag, ".y"}, 64'(y), 64'(ey));
    chk({tag, ".flags"}, 64'(flags), 64'(ef));
    chk({tag, ".busy_in_ready"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom; op = 3'($urandom);
      @(negedge clk);
      chk({tag, ".bp_y"}, 64'(y), 64'(ey));
      chk({tag, ".bp_flags"}, 64'(flags), 64'(ef));
      chk({tag, ".bp_out_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".bp_in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".idle_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".idle_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".idle_y_kept"}, 64'(y), 64'(ey));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;

    // Reset state
    @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.y", 64'(y), 64'd0);
    chk("rst.flags", 64'(flags), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op("add_ovf", 32'h7FFF_FFFF, 32'h1, 3'd2, 5);
    run_op("sub_eq", 32'd5, 32'd5, 3'd3, 0);
    run_op("sub_borrow", 32'd0, 32'd1, 3'd3, 1);
    run_op("slt_neg", 32'hFFFF_FFFF, 32'd1, 3'd5, 0);
    run_op("slt_pos", 32'd1, 32'hFFFF_FFFF, 3'd5, 0);
    run_op("shl_31", 32'd1, 32'd31, 3'd6, 0);
    run_op("shl_wrap", 32'hF000_000F, 32'd36, 3'd6, 0);
    run_op("mul_big", 32'h0001_0000, 32'h0001_0000, 3'd7, 2);
    run_op("mul_small", 32'd12345, 32'd678, 3'd7, 0);
    run_op("xor", 32'hA5A5_5A5A, 32'hFFFF_0000, 3'd4, 0);

    // Legacy 2-bit ops over single-bit operands
    for (int op_i = 0; op_i < 4; op_i++)
      for (int ai = 0; ai < 2; ai++)
        for (int bi = 0; bi < 2; bi++)
          run_op($sformatf("legacy_op%0d_a%0d_b%0d", op_i, ai, bi), 32'(ai), 32'(bi), 3'(op_i), 0);

    // Reset while an op (MUL) is in flight
    a = 32'h1234; b = 32'h5678; op = 3'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #2;
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.in_ready", 64'(in_ready), 64'd1);
    chk("midrst.y", 64'(y), 64'd0);
    chk("midrst.flags", 64'(flags), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst.out_valid", 64'(out_valid), 64'd0);
    chk("postrst.in_ready", 64'(in_ready), 64'd1);
    chk("postrst.y", 64'(y), 64'd0);
    run_op("postrst_mul", 32'd7, 32'd9, 3'd7, 0);
    run_op("postrst_add", 32'd40, 32'd2, 3'd2, 0);

    // Randomized traffic; operand classes bias toward sign/carry edges.
    for (int k = 0; k < 150; k++) begin
      rop = 3'($urandom);
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = 32'h7FFF_FFFF - 32'($urandom_range(0, 2)); rb = 32'($urandom_range(0, 3)); end
        2: begin ra = 32'h8000_0000 + 32'($urandom_range(0, 2)); rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 2)); end
        default: begin ra = 32'($urandom_range(0, 15)); rb = 32'($urandom_range(0, 15)); end
      endcase
      run_op($sformatf("rand%0d_op%0d", k, rop), ra, rb, rop, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised sequential ALU. It is the registered, handshaked successor to the 2-bit-select combinational ALU. Op codes 000-011 keep the legacy s-encoding in their low two bits (AND/OR/ADD/SUB); it adds XOR, SLT, SHL, an optional iterative multiply, status flags and valid/ready flow control. It sits between the operand-fetch stage and writeback in the CPU datapath.

Parameters:
WIDTH, 32, operand/result width in bits (must be >= 2)
SHW, $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0]

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operands/op presented
in_ready  out  1  block can accept an operation
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT (signed), 110 SHL, 111 MUL
out_valid  out  1  result held on y/flags
out_ready  in  1  consumer accepts result
y  out  WIDTH  result
flag_z  out  1  y == 0
flag_n  out  1  y[WIDTH-1]
flag_c  out  1  carry out (ADD), NOT borrow (SUB), else 0
flag_v  out  1  signed overflow (ADD/SUB), else 0
flag_err  out  1  unsupported op (MUL when the multiplier is compiled out)

Behaviour:
- Reset (async, any time, including mid-MUL): state=IDLE, in_ready=1, out_valid=0, y=0, all flags 0, multiply counter/accumulator cleared. After reset deasserts, the first edge behaves as IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. Accept on a clk edge with in_valid&in_ready.
  - Single-cycle ops: y and flags are registered on the accept edge, then -> DONE. out_valid=1 from the next cycle, so latency is 1 cycle.
  - MUL: latch a and b, clear the accumulator and the counter, -> BUSY.
- BUSY: in_ready=0. One shift-add step per cycle, with counter 0..WIDTH-1. After the step at counter==WIDTH-1: y = low WIDTH bits of a*b (unsigned), flag_c = |high WIDTH bits, flag_v=0. Then -> DONE. Latency from accept to out_valid is WIDTH+1 cycles.
- DONE: out_valid=1, in_ready=0. y and flags are stable until the handshake completes. On out_valid&out_ready: -> IDLE, out_valid=0 on the next cycle. y keeps its last value.
- No back-to-back overlap: in_ready is low whenever out_valid is high. in_valid while not ready is ignored, and operands are not sampled.
- Arithmetic:
  - ADD/SUB use WIDTH+1-bit sums, with SUB = a + ~b + 1.
  - flag_v = (a[msb]==b'[msb]) && (y[msb]!=a[msb]), where b' is b for ADD and ~b for SUB.
  - SLT: y = {WIDTH-1 zeros, signed(a)<signed(b)}.
  - SHL: y = a << b[SHW-1:0]. Bits shifted out are lost, and flag_c = 0.
- flag_z and flag_n always derive from the final y, for every op including MUL and the error case.

Optional Feature:
ALU_MUL_EN
- Defined: op 111 is the iterative multiplier above, and the BUSY state exists.
- Undefined: op 111 completes in 1 cycle like the other single-cycle ops, with y=0, flag_err=1, flag_z=1 and other flags 0. The BUSY state and multiplier registers are not synthesised.
- flag_err is 0 for all other ops in both builds.

Test Plan:
- Reset mid-operation: assert rst during a MUL BUSY cycle, then release -> out_valid=0, in_ready=1, y=0 and flags 0; the next op executes normally.
- WIDTH=32, ADD a=0x7FFFFFFF b=1, out_ready=1 -> out_valid 1 cycle after accept, y=0x80000000, v=1, n=1, c=0, z=0.
- SUB a=5 b=5 -> y=0, z=1, c=1, v=0. SUB a=0 b=1 -> y=0xFFFFFFFF, c=0, n=1.
- SLT a=0xFFFFFFFF b=1 -> y=1. SHL a=1 b=31 -> y=0x80000000. Legacy sweep with a,b in {0,1} over ops 000-011 matches AND/OR/ADD/SUB truth values.
- Backpressure: single-cycle ADD with out_ready=0 for 5 cycles -> y, flags and out_valid stable, in_ready=0, and in_valid pulses are ignored. out_ready=1 -> IDLE next cycle.
- ALU_MUL_EN defined: MUL a=0x10000 b=0x10000 -> out_valid after 33 cycles, y=0, c=1, z=1. With the macro undefined: flag_err=1 after 1 cycle.
